// File: rtl/ce_strobe_gen_if.sv
// Command/strobe bundle between a controller and ce_strobe_gen.
// Optional Phase member exists only when CE_STROBE_GEN_PHASE_EN is defined.
interface ce_strobe_gen_if #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 8
);
   logic                 Start;
   logic                 Stop;
   logic [WIDTH-1:0]     Div;
   logic [CNT_WIDTH-1:0] Burst;
   logic                 CE;
   logic                 Busy;
   logic                 Done;
   logic [CNT_WIDTH-1:0] Count;
`ifdef CE_STROBE_GEN_PHASE_EN
   logic [WIDTH-1:0]     Phase;

   modport master (output Start, Stop, Div, Burst, Phase, input CE, Busy, Done, Count);
   modport slave  (input Start, Stop, Div, Burst, Phase, output CE, Busy, Done, Count);
`else
   modport master (output Start, Stop, Div, Burst, input CE, Busy, Done, Count);
   modport slave  (input Start, Stop, Div, Burst, output CE, Busy, Done, Count);
`endif
endinterface

// File: rtl/ce_strobe_gen.sv
// Programmable CE strobe generator: latched divide ratio and burst length, with Stop abort.
// Define CE_STROBE_GEN_PHASE_EN to add a latched start-phase delay (Phase input).
module ce_strobe_gen #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic           CLK,
   input  logic           RESET,
   ce_strobe_gen_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]     ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] ONE_C = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     div_q, div_d;
   logic [WIDTH-1:0]     cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] burst_q, burst_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic                 ce_q, ce_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     div_eff_s;
   logic [WIDTH-1:0]     phase_s;

   assign div_eff_s = (bus.Div == '0) ? ONE_W : bus.Div;

`ifdef CE_STROBE_GEN_PHASE_EN
   assign phase_s = bus.Phase;
`else
   assign phase_s = '0;
`endif

   // cnt_q counts cycles until the next pulse; a pulse is launched from the edge where it reads 0.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      burst_d = burst_q;
      count_d = count_q;
      ce_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.Start && !bus.Stop) begin
               state_d = RUN;
               busy_d  = 1'b1;
               div_d   = div_eff_s;
               burst_d = bus.Burst;
               if (phase_s == '0) begin
                  ce_d    = 1'b1;
                  count_d = ONE_C;
                  cnt_d   = div_eff_s - ONE_W;
               end else begin
                  count_d = '0;
                  cnt_d   = phase_s - ONE_W;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (bus.Stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (ce_q && (burst_q != '0) && (count_q == burst_q)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (cnt_q == '0) begin
               ce_d    = 1'b1;
               count_d = count_q + ONE_C;
               cnt_d   = div_q - ONE_W;
            end else begin
               cnt_d   = cnt_q - ONE_W;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; RESET overrides everything.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         burst_q <= '0;
         count_q <= '0;
         ce_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         burst_q <= burst_d;
         count_q <= count_d;
         ce_q    <= ce_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.CE    = ce_q;
   assign bus.Busy  = busy_q;
   assign bus.Done  = done_q;
   assign bus.Count = count_q;

endmodule

// File: tb/tb_ce_strobe_gen.sv
// Scoreboard bench for ce_strobe_gen: directed runs push expected CE/Done events,
// a negedge monitor pops and compares them whenever CE or Done is high.
module tb_ce_strobe_gen;
   localparam int WIDTH     = 16;
   localparam int CNT_WIDTH = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ce_strobe_gen_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

   ce_strobe_gen #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   typedef struct {
      int cyc;
      bit done;
      int cnt;
   } ev_t;

   ev_t exp_q[$];
   int  cyc    = 0;
   int  base   = 0;
   int  checks = 0;
   int  errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int n);
      while (cyc < base + n) step();
   endtask

   task automatic expect_ev(input int n, input bit d, input int c);
      ev_t e;
      e.cyc  = base + n;
      e.done = d;
      e.cnt  = c;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Start is sampled in cycle 0 (base); inputs are scrambled afterwards.
   task automatic start_run(input int d, input int b);
      bus.Start = 1'b1;
      bus.Div   = d[15:0];
      bus.Burst = b[7:0];
      base      = cyc;
      step();
      bus.Start = 1'b0;
      bus.Div   = 16'd9;
      bus.Burst = 8'd1;
   endtask

   task automatic drain(input string name, input int maxc);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < maxc) begin
         step();
         k++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: every CE or Done cycle must match the head of the expected queue.
   always @(negedge clk) begin
      ev_t e;
      if (bus.CE || bus.Done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: cycle %0d ce=%0b done=%0b count=%0d, required no output",
                     cyc - base, bus.CE, bus.Done, bus.Count);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || bus.Done != e.done || bus.CE == e.done ||
                int'(bus.Count) != e.cnt || bus.Busy == e.done) begin
               errors++;
               $display("FAIL event: got cycle %0d ce=%0b done=%0b busy=%0b count=%0d, required cycle %0d done=%0b count=%0d",
                        cyc - base, bus.CE, bus.Done, bus.Busy, bus.Count, e.cyc - base, e.done, e.cnt);
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      bus.Start = 1'b1;
      bus.Stop  = 1'b0;
      bus.Div   = 16'd3;
      bus.Burst = 8'd4;
`ifdef CE_STROBE_GEN_PHASE_EN
      bus.Phase = 16'd0;
`endif
      repeat (3) step();
      @(negedge clk);
      check("reset_ce", bus.CE, 0);
      check("reset_busy", bus.Busy, 0);
      check("reset_done", bus.Done, 0);
      check("reset_count", bus.Count, 0);
      bus.Start = 1'b0;
      step();
      rst = 1'b0;
      step();

      // Div=3, Burst=4: CE at 1,4,7,10; Done at 11; Busy 1..10
      start_run(3, 4);
      expect_ev(1, 1'b0, 1);
      expect_ev(4, 1'b0, 2);
      expect_ev(7, 1'b0, 3);
      expect_ev(10, 1'b0, 4);
      expect_ev(11, 1'b1, 4);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("t1_busy", bus.Busy, ((cyc - base >= 1) && (cyc - base <= 10)) ? 1 : 0);
         step();
      end
      drain("t1_drain", 5);
      check("t1_count_hold", bus.Count, 4);

      // Div=0 clamps to 1
      start_run(0, 5);
      for (int n = 1; n <= 5; n++) expect_ev(n, 1'b0, n);
      expect_ev(6, 1'b1, 5);
      drain("t2_drain", 20);

      // Free-run Div=2, ignored Start at 4, Stop at 9
      start_run(2, 0);
      for (int n = 1; n <= 5; n++) expect_ev(2 * n - 1, 1'b0, n);
      goto(4);
      bus.Start = 1'b1;
      bus.Div   = 16'd1;
      bus.Burst = 8'd2;
      goto(5);
      bus.Start = 1'b0;
      goto(9);
      bus.Stop = 1'b1;
      goto(10);
      bus.Stop = 1'b0;
      @(negedge clk);
      check("t3_ce_after_stop", bus.CE, 0);
      check("t3_busy_after_stop", bus.Busy, 0);
      check("t3_done_after_stop", bus.Done, 0);
      check("t3_count_after_stop", bus.Count, 5);
      repeat (6) step();
      drain("t3_drain", 1);

      // Start together with Stop in IDLE stays IDLE
      bus.Start = 1'b1;
      bus.Stop  = 1'b1;
      bus.Div   = 16'd1;
      bus.Burst = 8'd3;
      base      = cyc;
      step();
      bus.Start = 1'b0;
      bus.Stop  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_busy", bus.Busy, 0);
         step();
      end
      check("t4_count_kept", bus.Count, 5);
      drain("t4_drain", 1);

      // RESET mid-burst at cycle 6
      start_run(2, 10);
      for (int n = 1; n <= 3; n++) expect_ev(2 * n - 1, 1'b0, n);
      goto(6);
      rst = 1'b1;
      goto(7);
      rst = 1'b0;
      @(negedge clk);
      check("t5_ce", bus.CE, 0);
      check("t5_busy", bus.Busy, 0);
      check("t5_done", bus.Done, 0);
      check("t5_count", bus.Count, 0);
      repeat (5) step();
      drain("t5_drain", 1);

`ifdef CE_STROBE_GEN_PHASE_EN
      // Phase=2, Div=4, Burst=2: CE at 3,7; Done at 8
      bus.Phase = 16'd2;
      start_run(4, 2);
      bus.Phase = 16'd5;
      expect_ev(3, 1'b0, 1);
      expect_ev(7, 1'b0, 2);
      expect_ev(8, 1'b1, 2);
      @(negedge clk);
      check("t6_busy_in_phase", bus.Busy, 1);
      drain("t6_drain", 20);
      bus.Phase = 16'd0;
      repeat (2) step();
`endif

      // Free-run Div=1 for 300 pulses, Count wraps 255->0
      start_run(1, 0);
      for (int n = 1; n <= 300; n++) expect_ev(n, 1'b0, n % 256);
      goto(300);
      bus.Stop = 1'b1;
      goto(301);
      bus.Stop = 1'b0;
      @(negedge clk);
      check("t7_busy", bus.Busy, 0);
      check("t7_ce", bus.CE, 0);
      check("t7_count", bus.Count, 300 % 256);
      drain("t7_drain", 5);

      // Burst=1 back-to-back: Start held through Done cycle, accepted the cycle after
      start_run(1, 1);
      expect_ev(1, 1'b0, 1);
      expect_ev(2, 1'b1, 1);
      expect_ev(4, 1'b0, 1);
      expect_ev(5, 1'b1, 1);
      goto(2);
      bus.Start = 1'b1;
      bus.Div   = 16'd1;
      bus.Burst = 8'd1;
      goto(4);
      bus.Start = 1'b0;
      drain("t8_drain", 20);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
